// File: rtl/aes_pkg.sv
// Shared AES definitions for the forward and inverse ciphers: byte tables, mix
// matrices, the state type, the FSM encoding and the round-step functions.
package aes_pkg;

    localparam int unsigned BLOCK_W   = 128;
    localparam int unsigned KEY_IDX_W = 5;
    localparam int unsigned RND_W     = 4;

    // [column][row][bit]; column 0 / row 0 is byte 0 in the MSBs of a block
    typedef logic [0:3][0:3][7:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } fsm_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] ISBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Circulant mix matrices, indexed [row][column]
    localparam logic [0:3][0:3][7:0] MA = {
        8'h02, 8'h03, 8'h01, 8'h01,
        8'h01, 8'h02, 8'h03, 8'h01,
        8'h01, 8'h01, 8'h02, 8'h03,
        8'h03, 8'h01, 8'h01, 8'h02
    };

    localparam logic [0:3][0:3][7:0] IMA = {
        8'h0e, 8'h0b, 8'h0d, 8'h09,
        8'h09, 8'h0e, 8'h0b, 8'h0d,
        8'h0d, 8'h09, 8'h0e, 8'h0b,
        8'h0b, 8'h0d, 8'h09, 8'h0e
    };

    // Multiply by x modulo x^8+x^4+x^3+x+1 (0x11b)
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic state_t sub_bytes(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[c][r] = SBOX[s[c][r]];
        return o;
    endfunction

    function automatic state_t inv_sub_bytes(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[c][r] = ISBOX[s[c][r]];
        return o;
    endfunction

    // Row r rotates left by r columns
    function automatic state_t shift_rows(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[c][r] = s[(c + r) % 4][r];
        return o;
    endfunction

    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[(c + r) % 4][r] = s[c][r];
        return o;
    endfunction

    function automatic state_t mix_matrix(input state_t s, input logic [0:3][0:3][7:0] m);
        state_t     o;
        logic [7:0] acc;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gf_mul(m[r][k], s[c][k]);
                o[c][r] = acc;
            end
        end
        return o;
    endfunction

    function automatic state_t mix_columns(input state_t s);
        return mix_matrix(s, MA);
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        return mix_matrix(s, IMA);
    endfunction

    function automatic state_t add_round_key(input state_t s, input state_t k);
        return s ^ k;
    endfunction

endpackage

// File: rtl/aes_cipher_round.sv
// Combinational single-round datapath of the forward cipher: initial key
// whitening, a full middle round, or the final round without MixColumns.
module aes_round
    import aes_pkg::*;
(
    input  state_t st,
    input  state_t k_sch,
    input  logic   first,
    input  logic   last,
    output state_t next_st
);

    state_t sr_st;

    always_comb begin
        sr_st = shift_rows(sub_bytes(st));
        if (first)
            next_st = add_round_key(st, k_sch);
        else if (last)
            next_st = add_round_key(sr_st, k_sch);
        else
            next_st = add_round_key(mix_columns(sr_st), k_sch);
    end

endmodule

// File: rtl/aes_cipher.sv
// Iterative AES forward cipher, one round per clock, fed by an external round-key
// stream. Optional build macro AES_CIPHER_ZEROIZE_EN clears st/ct after each output.
module aes_cipher
    import aes_pkg::*;
#(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = Nk + 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BLOCK_W-1:0]   k_sch,
    input  logic [KEY_IDX_W-1:0] key_avail,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BLOCK_W-1:0]   pt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BLOCK_W-1:0]   ct,
    output logic                 busy
);

    localparam logic [RND_W-1:0] LAST_RND = RND_W'(Nr);

    fsm_e               state_q, state_d;
    logic [RND_W-1:0]   rnd_q, rnd_d;
    state_t             st_q, st_d, round_st;
    logic [BLOCK_W-1:0] ct_q, ct_d;
    logic               in_ready_q, out_valid_q, busy_q;

    aes_round u_round (
        .st      (st_q),
        .k_sch   (state_t'(k_sch)),
        .first   (rnd_q == '0),
        .last    (rnd_q == LAST_RND),
        .next_st (round_st)
    );

    // Next state: a round only fires when the presented key index matches rnd
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        st_d    = st_q;
        ct_d    = ct_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    st_d    = state_t'(pt);
                    rnd_d   = '0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (key_avail == KEY_IDX_W'(rnd_q)) begin
                    st_d = round_st;
                    if (rnd_q == LAST_RND) begin
                        ct_d    = round_st;
                        state_d = DONE;
                    end else begin
                        rnd_d = rnd_q + RND_W'(1);
                    end
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
`ifdef AES_CIPHER_ZEROIZE_EN
                    st_d = '0;
                    ct_d = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rnd_q       <= '0;
            st_q        <= '0;
            ct_q        <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            st_q        <= st_d;
            ct_q        <= ct_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d == ROUND);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign ct        = ct_q;

endmodule

// File: tb/tb_aes_cipher.sv
// Self-checking bench for aes_cipher: FIPS-197 vectors plus randomized blocks
// against an arithmetic AES model, with key-stream stalls, backpressure and reset.
module tb_aes_cipher;

    logic         clk;
    logic         rst_n;
    logic         sel8;
    logic [127:0] pt_drv, k_drv;
    logic [4:0]   ka_drv, ka4, ka8;
    logic         iv_drv, iv4, iv8, out_ready;
    logic         ir4, ir8, ov4, ov8, busy4, busy8;
    logic [127:0] ct4, ct8;
    logic         ir_s, ov_s, busy_s;
    logic [127:0] ct_s;

    int total = 0;
    int bad   = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] rk_m   [0:14];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign iv4    = !sel8 && iv_drv;
    assign iv8    = sel8 && iv_drv;
    assign ka4    = sel8 ? 5'd31 : ka_drv;
    assign ka8    = sel8 ? ka_drv : 5'd31;
    assign ir_s   = sel8 ? ir8 : ir4;
    assign ov_s   = sel8 ? ov8 : ov4;
    assign busy_s = sel8 ? busy8 : busy4;
    assign ct_s   = sel8 ? ct8 : ct4;

    aes_cipher #(.Nk(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .k_sch(k_drv), .key_avail(ka4),
        .in_valid(iv4), .in_ready(ir4), .pt(pt_drv),
        .out_valid(ov4), .out_ready(out_ready), .ct(ct4), .busy(busy4)
    );

    aes_cipher #(.Nk(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .k_sch(k_drv), .key_avail(ka8),
        .in_valid(iv8), .in_ready(ir8), .pt(pt_drv),
        .out_valid(ov8), .out_ready(out_ready), .ct(ct8), .busy(busy8)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b};
        return t[15-n -: 8];
    endfunction

    // S-box from the multiplicative inverse (x^254) followed by the affine map
    task automatic init_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] b, inv;
            b   = 8'(x);
            inv = 8'h00;
            if (b != 8'h00) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, b);
            end
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int          nr;
        nr   = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Byte array model; byte index = row + 4*column
    function automatic logic [127:0] model_encrypt(input logic [127:0] p, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ rk_m[0][127-8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < nr) begin
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_m[r][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- block driver ----------------
    task automatic run_block(input string name, input bit use8, input logic [127:0] p,
                             input logic [255:0] key, input bit has_exp,
                             input logic [127:0] exp_fixed, input int stall_at,
                             input int stall_len, input bit noisy, input int bp,
                             input int abort_at);
        int           nk, nr, need, exp_lat, lat;
        int           q[$];
        logic [127:0] exp_ct, snap;
        bit           acc, acc_pre, ok;
        nk = use8 ? 8 : 4;
        nr = nk + 6;
        expand_key(key, nk);
        exp_ct = has_exp ? exp_fixed : model_encrypt(p, nr);
        for (int i = 0; i <= nr; i++) begin
            if (noisy) repeat ($urandom_range(0, 2)) q.push_back(int'($urandom_range(0, 31)));
            q.push_back(i);
            if (i == stall_at) repeat (stall_len) q.push_back(i);
        end
        // Rounds consume key indices strictly in order, whenever the needed one shows up
        need    = 0;
        exp_lat = -1;
        for (int t = 0; t < q.size(); t++)
            if (exp_lat < 0 && q[t] == need) begin
                need++;
                if (need == nr + 1) exp_lat = t + 1;
            end

        sel8      = use8;
        pt_drv    = p;
        iv_drv    = 1'b1;
        ka_drv    = 5'd31;
        k_drv     = rand128();
        out_ready = 1'b0;
        acc       = 1'b0;
        for (int w = 0; w < 8 && !acc; w++) begin
            acc_pre = ir_s;
            @(posedge clk); #1;
            acc = acc_pre;
        end
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL %s accept: in_ready stayed %b, want 1", name, ir_s);
            iv_drv = 1'b0;
            return;
        end
        iv_drv = noisy;
        pt_drv = rand128();

        lat = -1;
        ok  = 1'b1;
        for (int t = 0; t < q.size() + 4; t++) begin
            if (abort_at >= 0 && t == abort_at) begin
                total++;
                if (busy_s !== 1'b1) begin
                    bad++;
                    $display("FAIL %s busy_before_reset: got %b want 1", name, busy_s);
                end
                #2 rst_n = 1'b0;
                #1;
                total++;
                if (ov_s !== 1'b0 || busy_s !== 1'b0 || ct_s !== '0) begin
                    bad++;
                    $display("FAIL %s reset_async: out_valid=%b busy=%b ct=%h want 0 0 0",
                             name, ov_s, busy_s, ct_s);
                end
                iv_drv = 1'b0;
                ka_drv = 5'd31;
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk); #1;
                total++;
                if (ir_s !== 1'b1 || ov_s !== 1'b0) begin
                    bad++;
                    $display("FAIL %s after_reset: in_ready=%b out_valid=%b want 1 0",
                             name, ir_s, ov_s);
                end
                return;
            end
            ka_drv = (t < q.size()) ? 5'(q[t]) : 5'd31;
            k_drv  = (int'(ka_drv) <= nr) ? rk_m[ka_drv] : rand128();
            @(posedge clk); #1;
            if (ov_s === 1'b1) begin
                lat = t + 1;
                break;
            end
            if (busy_s !== 1'b1 || ir_s !== 1'b0) ok = 1'b0;
        end
        ka_drv = 5'd31;

        total++;
        if (lat != exp_lat) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
            iv_drv = 1'b0;
            return;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s in_progress: busy/in_ready wrong before out_valid, want 1/0", name);
        end
        total++;
        if (ct_s !== exp_ct || busy_s !== 1'b0) begin
            bad++;
            $display("FAIL %s ct: got %h busy=%b want %h busy=0", name, ct_s, busy_s, exp_ct);
        end

        if (bp > 0) begin
            ok = 1'b1;
            for (int b = 0; b < bp; b++) begin
                snap   = ct_s;
                iv_drv = 1'b1;
                pt_drv = rand128();
                @(posedge clk); #1;
                if (ov_s !== 1'b1 || ct_s !== snap || ir_s !== 1'b0) ok = 1'b0;
            end
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL %s backpressure: ov=%b ir=%b ct=%h want 1 0 %h",
                         name, ov_s, ir_s, ct_s, exp_ct);
            end
        end

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        iv_drv    = 1'b0;
        total++;
        if (ov_s !== 1'b0 || ir_s !== 1'b1 || busy_s !== 1'b0) begin
            bad++;
            $display("FAIL %s handshake: out_valid=%b in_ready=%b busy=%b want 0 1 0",
                     name, ov_s, ir_s, busy_s);
        end
`ifdef AES_CIPHER_ZEROIZE_EN
        snap = '0;
`else
        snap = exp_ct;
`endif
        total++;
        if (ct_s !== snap) begin
            bad++;
            $display("FAIL %s ct_after: got %h want %h", name, ct_s, snap);
        end
    endtask

    // ---------------- tests ----------------
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_C3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({ov4, ov8, busy4, busy8} !== 4'b0000 || ct4 !== '0 || ct8 !== '0) begin
            bad++;
            $display("FAIL reset_state: ov=%b%b busy=%b%b ct4=%h ct8=%h want all 0",
                     ov4, ov8, busy4, busy8, ct4, ct8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({ir4, ir8} !== 2'b11 || {ov4, ov8} !== 2'b00) begin
            bad++;
            $display("FAIL reset_release: in_ready=%b%b out_valid=%b%b want 11 00",
                     ir4, ir8, ov4, ov8);
        end
    endtask

    task automatic test_fips();
        run_block("app_b", 1'b0, PT_B, {KEY_B, 128'h0}, 1'b1, CT_B, -1, 0, 1'b0, 0, -1);
        run_block("c1", 1'b0, PT_C, {KEY_C1, 128'h0}, 1'b1, CT_C1, -1, 0, 1'b0, 0, -1);
        run_block("c3", 1'b1, PT_C, KEY_C3, 1'b1, CT_C3, -1, 0, 1'b0, 0, -1);
    endtask

    task automatic test_key_stall();
        run_block("c1_stall", 1'b0, PT_C, {KEY_C1, 128'h0}, 1'b1, CT_C1, 5, 7, 1'b0, 0, -1);
    endtask

    task automatic test_backpressure();
        run_block("bp_app_b", 1'b0, PT_B, {KEY_B, 128'h0}, 1'b1, CT_B, -1, 0, 1'b1, 4, -1);
    endtask

    task automatic test_back_to_back();
        run_block("b2b_1", 1'b0, rand128(), {rand128(), 128'h0}, 1'b0, '0, -1, 0, 1'b0, 0, -1);
        run_block("b2b_2", 1'b0, rand128(), {rand128(), 128'h0}, 1'b0, '0, -1, 0, 1'b0, 0, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++)
            run_block("rand128", 1'b0, rand128(), {rand128(), 128'h0}, 1'b0, '0,
                      int'($urandom_range(0, 10)), int'($urandom_range(0, 3)), 1'b1,
                      int'($urandom_range(0, 3)), -1);
        for (int n = 0; n < 3; n++)
            run_block("rand256", 1'b1, rand128(), {rand128(), rand128()}, 1'b0, '0,
                      int'($urandom_range(0, 14)), int'($urandom_range(0, 3)), 1'b1,
                      int'($urandom_range(0, 3)), -1);
    endtask

    task automatic test_reset_mid();
        run_block("reset_mid", 1'b0, PT_B, {KEY_B, 128'h0}, 1'b1, CT_B, -1, 0, 1'b0, 0, 6);
        run_block("post_reset", 1'b0, PT_B, {KEY_B, 128'h0}, 1'b1, CT_B, -1, 0, 1'b0, 0, -1);
    endtask

    initial begin
        rst_n     = 1'b0;
        sel8      = 1'b0;
        pt_drv    = '0;
        k_drv     = '0;
        ka_drv    = 5'd31;
        iv_drv    = 1'b0;
        out_ready = 1'b0;
        init_sbox();
        test_reset();
        test_fips();
        test_key_stall();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
